// File: rtl/cpu_bus_cycle_initiator.sv
// rtl/cpu_bus_cycle_initiator.sv - 8088 max-mode bus-cycle initiator: T1..T4 with Tw, halt and locked two-cycle INTA
module cpu_bus_cycle_initiator #(
  parameter int WAIT_LIMIT = 1023,
  parameter int INTA_IDLE  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_type,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic [2:0]  processor_status,
  output logic        processor_lock_n,
  output logic [19:0] cpu_address,
  output logic [7:0]  cpu_data_bus,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        processor_ready
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam int IW = (INTA_IDLE < 1) ? 1 : $clog2(INTA_IDLE + 1);

  localparam logic [2:0] TY_INTA  = 3'b000;
  localparam logic [2:0] TY_IORD  = 3'b001;
  localparam logic [2:0] TY_IOWR  = 3'b010;
  localparam logic [2:0] TY_HALT  = 3'b011;
  localparam logic [2:0] TY_FETCH = 3'b100;
  localparam logic [2:0] TY_MRD   = 3'b101;
  localparam logic [2:0] TY_MWR   = 3'b110;
  localparam logic [2:0] TY_NONE  = 3'b111;

  typedef enum logic [2:0] {
    S_TI,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4,
    S_IDL
  } state_e;

  state_e         state_q, state_d;
  logic [19:0]    addr_q, addr_d;
  logic [2:0]     type_q, type_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           pass2_q, pass2_d;

  logic is_inta;
  logic is_read;
  logic is_write;
  logic inta_pend;
  logic accept;
  logic lock_first;
  logic lock_second;

  assign is_inta  = (type_q == TY_INTA);
  assign is_read  = is_inta || (type_q == TY_IORD) || (type_q == TY_FETCH) || (type_q == TY_MRD);
  assign is_write = (type_q == TY_IOWR) || (type_q == TY_MWR);

  // T4 of a first INTA cycle that completed normally: the locked second cycle must follow.
  assign inta_pend = (state_q == S_T4) && is_inta && !pass2_q && !err_q;

  assign req_ready = ((state_q == S_TI) || (state_q == S_T4)) && !inta_pend;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    type_d  = type_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    idle_d  = idle_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    pass2_d = pass2_q;
    case (state_q)
      S_TI, S_T4: begin
        if (inta_pend) begin
          pass2_d = 1'b1;
          if (INTA_IDLE == 0) begin
            state_d = S_T1;
          end else begin
            state_d = S_IDL;
            idle_d  = IW'(INTA_IDLE - 1);
          end
        end else if (accept && (req_type != TY_NONE)) begin
          state_d = S_T1;
          addr_d  = req_address;
          type_d  = req_type;
          wdata_d = req_wdata;
          rdata_d = 8'h00;
          err_d   = 1'b0;
          pass2_d = 1'b0;
        end else begin
          state_d = S_TI;
        end
      end
      S_T1: begin
        wait_d  = '0;
        state_d = (type_q == TY_HALT) ? S_T4 : S_T2;
      end
      S_T2: begin
        state_d = S_T3;
      end
      S_T3, S_TW: begin
        if (processor_ready) begin
          state_d = S_T4;
          if (is_read) begin
            rdata_d = cpu_data_in;
          end
        end else if (wait_q == CW'(WAIT_LIMIT)) begin
          state_d = S_T4;
          err_d   = 1'b1;
          rdata_d = 8'hFF;
        end else begin
          state_d = S_TW;
          wait_d  = wait_q + CW'(1);
        end
      end
      S_IDL: begin
        if (idle_q == '0) begin
          state_d = S_T1;
        end else begin
          idle_d = idle_q - IW'(1);
        end
      end
      default: begin
        state_d = S_TI;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_TI;
      addr_q  <= 20'h00000;
      type_q  <= TY_NONE;
      wdata_q <= 8'h00;
      wait_q  <= '0;
      idle_q  <= '0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      pass2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      idle_q  <= idle_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      pass2_q <= pass2_d;
    end
  end

  assign processor_status = ((state_q == S_T1) || (state_q == S_T2) ||
                             (state_q == S_T3) || (state_q == S_TW)) ? type_q : 3'b111;

  assign cpu_address  = addr_q;
  assign cpu_data_oe  = is_write && ((state_q == S_T2) || (state_q == S_T3) ||
                                     (state_q == S_TW) || (state_q == S_T4));
  assign cpu_data_bus = cpu_data_oe ? wdata_q : 8'h00;

  // Lock spans first T2 through second T2; a timed-out first cycle releases it in its own T4.
  assign lock_first  = is_inta && !pass2_q &&
                       ((state_q == S_T2) || (state_q == S_T3) || (state_q == S_TW) ||
                        ((state_q == S_T4) && !err_q));
  assign lock_second = is_inta && pass2_q &&
                       ((state_q == S_IDL) || (state_q == S_T1) || (state_q == S_T2));
  assign processor_lock_n = !(lock_first || lock_second);

  assign rsp_valid = (state_q == S_T4) && !inta_pend;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_cpu_bus_cycle_initiator.sv
// tb/tb_cpu_bus_cycle_initiator.sv - randomized self-checking bench for cpu_bus_cycle_initiator
module tb_cpu_bus_cycle_initiator;

  localparam int WL   = 4;
  localparam int IDLE = 2;

  localparam logic [2:0] TY_INTA  = 3'b000;
  localparam logic [2:0] TY_IORD  = 3'b001;
  localparam logic [2:0] TY_IOWR  = 3'b010;
  localparam logic [2:0] TY_HALT  = 3'b011;
  localparam logic [2:0] TY_FETCH = 3'b100;
  localparam logic [2:0] TY_MRD   = 3'b101;
  localparam logic [2:0] TY_MWR   = 3'b110;
  localparam logic [2:0] TY_NONE  = 3'b111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_type = 3'b111;
  logic [19:0] req_address = 20'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic [2:0]  processor_status;
  logic        processor_lock_n;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_data_bus;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in = 8'h0;
  logic        processor_ready = 1'b1;

  cpu_bus_cycle_initiator #(.WAIT_LIMIT(WL), .INTA_IDLE(IDLE)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_type         (req_type),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .processor_status (processor_status),
    .processor_lock_n (processor_lock_n),
    .cpu_address      (cpu_address),
    .cpu_data_bus     (cpu_data_bus),
    .cpu_data_oe      (cpu_data_oe),
    .cpu_data_in      (cpu_data_in),
    .processor_ready  (processor_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  ty;
    logic [19:0] a;
    logic [7:0]  wd;
    int          n1;
    int          n2;
    logic [7:0]  d1;
    logic [7:0]  d2;
    bit          b2b;
  } req_t;

  typedef struct {
    logic [2:0]  st;
    logic        lk;
    logic        oe;
    logic [7:0]  db;
    logic [19:0] addr;
    logic        rv;
    logic        rr;
    logic        re;
    logic [7:0]  rd;
    bit          chk_rd;
    logic        rdy;
    logic [7:0]  din;
  } exp_t;

  req_t reqs[$];
  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic req_t mk(input logic [2:0] ty, input logic [19:0] a, input logic [7:0] wd,
                              input int n1, input int n2, input logic [7:0] d1,
                              input logic [7:0] d2, input bit b2b);
    req_t r;
    r.ty = ty; r.a = a; r.wd = wd; r.n1 = n1; r.n2 = n2; r.d1 = d1; r.d2 = d2; r.b2b = b2b;
    return r;
  endfunction

  // One bus cycle as a per-clock timeline; kind 0 plain, 1 first INTA, 2 second INTA.
  task automatic push_cycle(input logic [2:0] ty, input logic [19:0] a, input logic [7:0] wd,
                            input int n, input logic [7:0] dfin, input int kind, output bit err);
    exp_t e;
    bit   wr, rd, halt, last;
    int   w, nclk;
    halt = (ty == TY_HALT);
    wr   = (ty == TY_IOWR) || (ty == TY_MWR);
    rd   = (ty == TY_INTA) || (ty == TY_IORD) || (ty == TY_FETCH) || (ty == TY_MRD);
    err  = !halt && (n > WL);
    w    = (n > WL) ? WL : n;
    nclk = halt ? 2 : 4 + w;
    for (int k = 1; k <= nclk; k++) begin
      last   = (k == nclk);
      e.addr = a;
      e.st   = last ? 3'b111 : ty;
      e.oe   = wr && (k >= 2);
      e.db   = wd;
      e.rdy  = 1'($urandom);
      e.din  = 8'($urandom);
      if (!halt && k >= 3 && !last) e.rdy = ((k - 3) >= n);
      if (!halt && k == nclk - 1) e.din = dfin;
      case (kind)
        1:       e.lk = (k >= 2 && !(last && err)) ? 1'b0 : 1'b1;
        2:       e.lk = (k <= 2) ? 1'b0 : 1'b1;
        default: e.lk = 1'b1;
      endcase
      e.rv     = last && !(kind == 1 && !err);
      e.rr     = e.rv;
      e.re     = err;
      e.rd     = err ? 8'hFF : (rd ? dfin : 8'h00);
      e.chk_rd = !wr || err;
      q.push_back(e);
    end
  endtask

  task automatic build(input req_t r);
    bit   err;
    exp_t e;
    if (r.ty == TY_NONE) return;
    if (r.ty != TY_INTA) begin
      push_cycle(r.ty, r.a, r.wd, r.n1, r.d1, 0, err);
      return;
    end
    push_cycle(r.ty, r.a, r.wd, r.n1, r.d1, 1, err);
    if (err) return;
    for (int k = 0; k < IDLE; k++) begin
      e.st = 3'b111; e.lk = 1'b0; e.oe = 1'b0; e.db = 8'h00; e.addr = r.a;
      e.rv = 1'b0; e.rr = 1'b0; e.re = 1'b0; e.rd = 8'h00; e.chk_rd = 1'b0;
      e.rdy = 1'($urandom); e.din = 8'($urandom);
      q.push_back(e);
    end
    push_cycle(r.ty, r.a, r.wd, r.n2, r.d2, 2, err);
  endtask

  task automatic present(input req_t r);
    req_valid   = 1'b1;
    req_type    = r.ty;
    req_address = r.a;
    req_wdata   = r.wd;
  endtask

  task automatic idle_step(input int i);
    @(negedge clock);
    total++; if (processor_status !== 3'b111) $display("FAIL idle_status: req %0d got %b exp 111", i, processor_status); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL idle_rsp_valid: req %0d got %b exp 0", i, rsp_valid); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready: req %0d got %b exp 1", i, req_ready); else passed++;
    total++; if (processor_lock_n !== 1'b1) $display("FAIL idle_lock_n: req %0d got %b exp 1", i, processor_lock_n); else passed++;
    total++; if (cpu_data_oe !== 1'b0) $display("FAIL idle_oe: req %0d got %b exp 0", i, cpu_data_oe); else passed++;
    if (i + 1 < reqs.size()) present(reqs[i+1]);
    else req_valid = 1'b0;
  endtask

  task automatic run_reqs();
    exp_t e;
    int   n;
    @(negedge clock);
    present(reqs[0]);
    for (int i = 0; i < reqs.size(); i++) begin
      total++; if (req_ready !== 1'b1) $display("FAIL accept_ready: req %0d got %b exp 1", i, req_ready); else passed++;
      @(posedge clock);
      q.delete();
      build(reqs[i]);
      n = q.size();
      for (int j = 0; j < n; j++) begin
        @(negedge clock);
        e = q[j];
        processor_ready = e.rdy;
        cpu_data_in     = e.din;
        if (j == 0) req_valid = 1'b0;
        total++; if (processor_status !== e.st) $display("FAIL status: req %0d clk %0d got %b exp %b", i, j+1, processor_status, e.st); else passed++;
        total++; if (processor_lock_n !== e.lk) $display("FAIL lock_n: req %0d clk %0d got %b exp %b", i, j+1, processor_lock_n, e.lk); else passed++;
        total++; if (cpu_data_oe !== e.oe) $display("FAIL data_oe: req %0d clk %0d got %b exp %b", i, j+1, cpu_data_oe, e.oe); else passed++;
        if (e.oe) begin
          total++; if (cpu_data_bus !== e.db) $display("FAIL data_bus: req %0d clk %0d got %h exp %h", i, j+1, cpu_data_bus, e.db); else passed++;
        end
        total++; if (cpu_address !== e.addr) $display("FAIL address: req %0d clk %0d got %h exp %h", i, j+1, cpu_address, e.addr); else passed++;
        total++; if (rsp_valid !== e.rv) $display("FAIL rsp_valid: req %0d clk %0d got %b exp %b", i, j+1, rsp_valid, e.rv); else passed++;
        total++; if (req_ready !== e.rr) $display("FAIL req_ready: req %0d clk %0d got %b exp %b", i, j+1, req_ready, e.rr); else passed++;
        if (e.rv) begin
          total++; if (rsp_error !== e.re) $display("FAIL rsp_error: req %0d got %b exp %b", i, rsp_error, e.re); else passed++;
          if (e.chk_rd) begin
            total++; if (rsp_rdata !== e.rd) $display("FAIL rsp_rdata: req %0d got %h exp %h", i, rsp_rdata, e.rd); else passed++;
          end
        end
        if (j == n - 1 && i + 1 < reqs.size() && reqs[i+1].b2b) present(reqs[i+1]);
      end
      if (n == 0 || !(i + 1 < reqs.size() && reqs[i+1].b2b)) idle_step(i);
    end
    reqs.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (processor_status !== 3'b111) $display("FAIL reset_status: got %b exp 111", processor_status); else passed++;
    total++; if (processor_lock_n !== 1'b1) $display("FAIL reset_lock_n: got %b exp 1", processor_lock_n); else passed++;
    total++; if (cpu_address !== 20'h0) $display("FAIL reset_address: got %h exp 00000", cpu_address); else passed++;
    total++; if (cpu_data_bus !== 8'h0) $display("FAIL reset_data_bus: got %h exp 00", cpu_data_bus); else passed++;
    total++; if (cpu_data_oe !== 1'b0) $display("FAIL reset_oe: got %b exp 0", cpu_data_oe); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else passed++;
    total++; if (rsp_error !== 1'b0) $display("FAIL reset_rsp_error: got %b exp 0", rsp_error); else passed++;
    total++; if (rsp_rdata !== 8'h0) $display("FAIL reset_rsp_rdata: got %h exp 00", rsp_rdata); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", req_ready); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_mem_read();
    reqs.push_back(mk(TY_MRD, 20'hF0000, 8'h00, 0, 0, 8'hEA, 8'h00, 1'b0));
    run_reqs();
  endtask

  task automatic test_io_write();
    reqs.push_back(mk(TY_IOWR, 20'h00061, 8'h4B, 3, 0, 8'h00, 8'h00, 1'b0));
    run_reqs();
  endtask

  task automatic test_inta();
    reqs.push_back(mk(TY_INTA, 20'h00000, 8'h00, 0, 1, 8'h5A, 8'h08, 1'b0));
    reqs.push_back(mk(TY_INTA, 20'h00000, 8'h00, 7, 0, 8'h11, 8'h22, 1'b0));
    run_reqs();
  endtask

  task automatic test_timeout();
    reqs.push_back(mk(TY_FETCH, 20'hFFFF0, 8'h00, 100, 0, 8'h33, 8'h00, 1'b0));
    reqs.push_back(mk(TY_FETCH, 20'hFFFF1, 8'h00, WL, 0, 8'h44, 8'h00, 1'b0));
    run_reqs();
  endtask

  task automatic test_halt_and_drop();
    reqs.push_back(mk(TY_HALT, 20'h12345, 8'h00, 0, 0, 8'h00, 8'h00, 1'b0));
    reqs.push_back(mk(TY_NONE, 20'h54321, 8'h00, 0, 0, 8'h00, 8'h00, 1'b0));
    reqs.push_back(mk(TY_IORD, 20'h00060, 8'h00, 1, 0, 8'h9C, 8'h00, 1'b0));
    run_reqs();
  endtask

  task automatic test_back_to_back();
    reqs.push_back(mk(TY_MWR, 20'h10000, 8'hA5, 0, 0, 8'h00, 8'h00, 1'b0));
    reqs.push_back(mk(TY_MWR, 20'h10001, 8'h5A, 0, 0, 8'h00, 8'h00, 1'b1));
    reqs.push_back(mk(TY_MRD, 20'h10002, 8'h00, 2, 0, 8'h77, 8'h00, 1'b1));
    run_reqs();
  endtask

  task automatic test_reset_midcycle();
    @(negedge clock);
    req_valid = 1'b1; req_type = TY_IORD; req_address = 20'h003F8; processor_ready = 1'b0;
    @(posedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      req_valid = 1'b0;
      processor_ready = 1'b0;
    end
    total++; if (processor_status !== TY_IORD) $display("FAIL pre_reset_status: got %b exp %b", processor_status, TY_IORD); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (processor_status !== 3'b111) $display("FAIL midreset_status: got %b exp 111", processor_status); else passed++;
    total++; if (cpu_address !== 20'h0) $display("FAIL midreset_address: got %h exp 00000", cpu_address); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL midreset_req_ready: got %b exp 1", req_ready); else passed++;
    total++; if (rsp_rdata !== 8'h0) $display("FAIL midreset_rsp_rdata: got %h exp 00", rsp_rdata); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      processor_ready = 1'b1;
      total++; if (rsp_valid !== 1'b0) $display("FAIL midreset_rsp_valid: clk %0d got %b exp 0", k, rsp_valid); else passed++;
    end
    reset = 1'b1;
    reqs.push_back(mk(TY_MRD, 20'h0ABCD, 8'h00, 1, 0, 8'hC3, 8'h00, 1'b0));
    run_reqs();
  endtask

  task automatic test_random();
    logic [2:0] ty;
    for (int i = 0; i < 60; i++) begin
      ty = 3'($urandom_range(0, 7));
      reqs.push_back(mk(ty, 20'($urandom), 8'($urandom),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(5, 6) : $urandom_range(0, 4),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(5, 6) : $urandom_range(0, 4),
                        8'($urandom), 8'($urandom), 1'($urandom)));
    end
    run_reqs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_inta();
    test_timeout();
    test_halt_and_drop();
    test_back_to_back();
    test_reset_midcycle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
